// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared types and constants for the two-digit seven-segment
//               scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    typedef enum logic [1:0] {
        ONES_ON = 2'd0,
        BLANK_A = 2'd1,
        TENS_ON = 2'd2,
        BLANK_B = 2'd3
    } state_e;

    // Active-high "0" glyph; segments a..f lit, g dark.
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;
    localparam logic [6:0] SEG_OFF_N = 7'h7F;
    localparam logic [1:0] AN_OFF_N  = 2'b11;

endpackage : ssd_pkg
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_driver
// Description : Time-multiplexes tens/ones segment patterns onto a shared
//               active-low cathode bus with dead-time and zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       lz_blank,
    input  logic [6:0] seg_tens,
    input  logic [6:0] seg_ones,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [1:0] an_n,
    output logic       frame_tick
);

    localparam int c_MAX_DWELL = (REFRESH_DIV > BLANK_CYCLES) ?
                                 ((REFRESH_DIV > 2) ? REFRESH_DIV : 2) :
                                 ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int c_CNT_W     = $clog2(c_MAX_DWELL);
    localparam bit c_HAS_BLANK = (BLANK_CYCLES > 0);
    localparam logic [c_CNT_W-1:0] c_ON_LAST    = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST =
        c_CNT_W'(c_HAS_BLANK ? (BLANK_CYCLES - 1) : 0);

    state_e             r_state_q, w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [6:0]         r_snap_tens_q, w_snap_tens_d;
    logic [6:0]         r_snap_ones_q, w_snap_ones_d;
    logic [1:0]         r_an_q,    w_an_d;
    logic [6:0]         r_seg_q,   w_seg_d;
    logic               r_tick_q,  w_tick_d;
    logic               w_last;
    logic               w_enter_ones;

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q + 1'b1;
        w_last        = 1'b0;
        w_enter_ones  = 1'b0;
        w_snap_tens_d = r_snap_tens_q;
        w_snap_ones_d = r_snap_ones_q;
        w_an_d        = AN_OFF_N;
        w_seg_d       = SEG_OFF_N;
        w_tick_d      = 1'b0;

        // With no dead-time the blank states are only reachable from reset
        // and are left after a single cycle.
        case (r_state_q)
            ONES_ON, TENS_ON: w_last = (r_cnt_q == c_ON_LAST);
            default:          w_last = !c_HAS_BLANK || (r_cnt_q == c_BLANK_LAST);
        endcase

        if (w_last) begin
            w_cnt_d = '0;
            case (r_state_q)
                ONES_ON: w_state_d = c_HAS_BLANK ? BLANK_A : TENS_ON;
                BLANK_A: w_state_d = TENS_ON;
                TENS_ON: w_state_d = c_HAS_BLANK ? BLANK_B : ONES_ON;
                default: w_state_d = ONES_ON;
            endcase
        end

        w_enter_ones = (w_state_d == ONES_ON) && (r_state_q != ONES_ON);
        if (w_enter_ones) begin
            w_snap_tens_d = seg_tens;
            w_snap_ones_d = seg_ones;
        end
        w_tick_d = w_enter_ones;

        // Pins follow the next state so they switch on the same edge.
        if (en) begin
            case (w_state_d)
                ONES_ON: begin
                    w_an_d  = 2'b10;
                    w_seg_d = ~w_snap_ones_d;
                end
                TENS_ON: begin
                    if (!(lz_blank && (w_snap_tens_d == SEG_ZERO))) begin
                        w_an_d  = 2'b01;
                        w_seg_d = ~w_snap_tens_d;
                    end
                end
                default: begin
                    w_an_d  = AN_OFF_N;
                    w_seg_d = SEG_OFF_N;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= BLANK_B;
            r_cnt_q       <= '0;
            r_snap_tens_q <= 7'h00;
            r_snap_ones_q <= 7'h00;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_snap_tens_q <= w_snap_tens_d;
            r_snap_ones_q <= w_snap_ones_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an_q   <= AN_OFF_N;
            r_seg_q  <= SEG_OFF_N;
            r_tick_q <= 1'b0;
        end else begin
            r_an_q   <= w_an_d;
            r_seg_q  <= w_seg_d;
            r_tick_q <= w_tick_d;
        end
    end

    assign an_n       = r_an_q;
    assign seg_n      = r_seg_q;
    assign frame_tick = r_tick_q;
    assign dp_n       = 1'b1;

endmodule : ssd_scan_driver
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_driver
// Description : Directed self-checking bench for ssd_scan_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_driver;
    import ssd_pkg::*;

    localparam logic [6:0] c_TWO   = 7'b1011011;
    localparam logic [6:0] c_THREE = 7'b1001111;
    localparam logic [6:0] c_SEVEN = 7'b0000111;

    logic       clk = 1'b0;
    logic       rst, rst0, en, lz_blank;
    logic [6:0] seg_tens, seg_ones;
    logic [6:0] seg_n, seg0_n;
    logic       dp_n, dp0_n, frame_tick, tick0;
    logic [1:0] an_n, an0_n;

    int         errors = 0;
    int         checks = 0;
    int         ph = 0;
    logic [6:0] m_tens = 7'h00, m_ones = 7'h00;
    logic [6:0] pre_tens, pre_ones;
    logic       e_en = 1'b1, e_lz = 1'b0;

    always #5 clk = ~clk;

    ssd_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .lz_blank(lz_blank),
        .seg_tens(seg_tens), .seg_ones(seg_ones),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
    );

    ssd_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .en(en), .lz_blank(lz_blank),
        .seg_tens(seg_tens), .seg_ones(seg_ones),
        .seg_n(seg0_n), .dp_n(dp0_n), .an_n(an0_n), .frame_tick(tick0)
    );

    always @(negedge clk) begin
        if (an_n === 2'b00 || an0_n === 2'b00) begin
            errors++;
            $display("FAIL an_both_low an_n=%b an0_n=%b required never 00", an_n, an0_n);
        end
    end

    // Phase model: 0-3 ones lit, 4-5 blank, 6-9 tens lit, 10-11 blank.
    task automatic step();
        e_en     = en;
        e_lz     = lz_blank;
        pre_tens = seg_tens;
        pre_ones = seg_ones;
        @(posedge clk);
        #1;
        ph = (ph + 1) % 12;
        if (ph == 0) begin
            m_tens = pre_tens;
            m_ones = pre_ones;
        end
    endtask

    function automatic logic [9:0] exp_out();
        logic [1:0] an;
        logic [6:0] sg;
        an = AN_OFF_N;
        sg = SEG_OFF_N;
        if (e_en && ph < 4) begin
            an = 2'b10;
            sg = ~m_ones;
        end else if (e_en && ph >= 6 && ph <= 9 && !(e_lz && m_tens == SEG_ZERO)) begin
            an = 2'b01;
            sg = ~m_tens;
        end
        return {an, sg, (ph == 0)};
    endfunction

    task automatic test_reset();
        en = 1'b1; lz_blank = 1'b0; seg_tens = c_TWO; seg_ones = c_THREE;
        rst = 1'b1; rst0 = 1'b1;
        step(); step();
        checks += 4;
        if (an_n !== 2'b11) begin errors++; $display("FAIL reset_an got=%b exp=11", an_n); end
        if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg_n); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp_n); end
        rst = 1'b0;
        ph = 10;
        m_tens = 7'h00; m_ones = 7'h00;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 24; i++) begin
            step();
            checks++;
            if ({an_n, seg_n, frame_tick} !== exp_out()) begin
                errors++;
                $display("FAIL basic ph=%0d got=%b exp=%b", ph, {an_n, seg_n, frame_tick}, exp_out());
            end
            if (ph == 0) begin
                checks++;
                if (seg_n !== 7'b0110000) begin errors++; $display("FAIL basic_ones got=%b exp=0110000", seg_n); end
            end
            if (ph == 6) begin
                checks++;
                if (seg_n !== 7'b0100100) begin errors++; $display("FAIL basic_tens got=%b exp=0100100", seg_n); end
            end
        end
    endtask

    task automatic test_snapshot();
        for (int i = 0; i < 12 && ph != 6; i++) step();
        seg_ones = c_SEVEN;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({an_n, seg_n, frame_tick} !== exp_out()) begin
                errors++;
                $display("FAIL snapshot ph=%0d got=%b exp=%b", ph, {an_n, seg_n, frame_tick}, exp_out());
            end
            if (ph == 0) begin
                checks++;
                if (seg_n !== 7'b1111000) begin errors++; $display("FAIL snapshot_new got=%b exp=1111000", seg_n); end
            end
        end
    endtask

    task automatic test_lz();
        for (int i = 0; i < 12 && ph != 11; i++) step();
        seg_tens = SEG_ZERO;
        lz_blank = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 12; i++) begin
                step();
                checks++;
                if ({an_n, seg_n, frame_tick} !== exp_out()) begin
                    errors++;
                    $display("FAIL lz ph=%0d lz=%b got=%b exp=%b", ph, e_lz, {an_n, seg_n, frame_tick}, exp_out());
                end
                if (ph == 6) begin
                    checks++;
                    if (f == 0 && {an_n, seg_n} !== {2'b11, 7'h7F}) begin
                        errors++; $display("FAIL lz_on got=%b exp=11_1111111", {an_n, seg_n});
                    end
                    if (f == 1 && {an_n, seg_n} !== {2'b01, 7'b1000000}) begin
                        errors++; $display("FAIL lz_off got=%b exp=01_1000000", {an_n, seg_n});
                    end
                end
            end
            lz_blank = 1'b0;
        end
    endtask

    task automatic test_en();
        for (int i = 0; i < 12 && ph != 1; i++) step();
        en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 5) en = 1'b1;
            step();
            checks++;
            if ({an_n, seg_n, frame_tick} !== exp_out()) begin
                errors++;
                $display("FAIL en ph=%0d en=%b got=%b exp=%b", ph, e_en, {an_n, seg_n, frame_tick}, exp_out());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 12 && ph != 7; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if ({an_n, seg_n, frame_tick} !== {2'b11, 7'h7F, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=11_1111111_0", {an_n, seg_n, frame_tick});
        end
        rst = 1'b0;
        ph = 10;
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if ({an_n, seg_n, frame_tick} !== exp_out()) begin
                errors++;
                $display("FAIL reset_mid_run ph=%0d got=%b exp=%b", ph, {an_n, seg_n, frame_tick}, exp_out());
            end
        end
    endtask

    task automatic test_no_blank();
        logic [1:0] an_e;
        logic [6:0] sg_e;
        int         p;
        seg_tens = c_TWO; seg_ones = c_THREE; lz_blank = 1'b0; en = 1'b1;
        step();
        rst0 = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            step();
            p    = (i - 1) % 8;
            an_e = (p < 4) ? 2'b10 : 2'b01;
            sg_e = (p < 4) ? 7'b0110000 : 7'b0100100;
            checks++;
            if ({an0_n, seg0_n, tick0} !== {an_e, sg_e, (p == 0)}) begin
                errors++;
                $display("FAIL no_blank cyc=%0d got=%b exp=%b", i, {an0_n, seg0_n, tick0}, {an_e, sg_e, (p == 0)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_lz();
        test_en();
        test_reset_mid();
        test_no_blank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ssd_scan_driver
`default_nettype wire

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Downstream stage of the adder/BCD/seven-segment decode chain.
- Consumes the two active-high 7-bit segment patterns, tens and ones, with bit0=a through bit6=g.
- Time-multiplexes the two patterns onto the board's shared, active-low cathode bus with active-low digit anodes, so both digits appear lit.
- Adds dead-time blanking, frame-synchronous input snapshotting and optional leading-zero suppression.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit per slot; must be ≥1.
- BLANK_CYCLES, 1000: dead-time cycles with all anodes off between slots; 0 removes the blank states.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  display enable; low forces all anodes off while the FSM keeps running.
- lz_blank  in  1  when high, suppress the tens digit if its snapshot equals the "0" pattern.
- seg_tens  in  7  active-high segment pattern for the tens digit.
- seg_ones  in  7  active-high segment pattern for the ones digit.
- seg_n  out  7  active-low cathodes, bit0=a through bit6=g.
- dp_n  out  1  active-low decimal point; constant 1.
- an_n  out  2  active-low anodes; bit0=ones, bit1=tens.
- frame_tick  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - state=BLANK_B, cnt=0.
  - snap_tens=snap_ones=7'h00.
  - an_n=2'b11, seg_n=7'h7F, dp_n=1, frame_tick=0.
- Reset mid-operation: same values on the next edge, regardless of state.
- States, cycled in this order: ONES_ON → BLANK_A → TENS_ON → BLANK_B → ONES_ON.
- Dwell times:
  - ONES_ON and TENS_ON: REFRESH_DIV cycles each.
  - BLANK_A and BLANK_B: BLANK_CYCLES cycles each.
  - cnt counts 0..dwell-1 within a state; on the terminal count the state advances and cnt returns to 0.
  - If BLANK_CYCLES=0, the blank states are skipped: ONES_ON→TENS_ON→ONES_ON.
- Frame period: 2*(REFRESH_DIV+BLANK_CYCLES) cycles.
- First lit slot: after reset release, ONES_ON is entered after BLANK_CYCLES cycles, or immediately if BLANK_CYCLES=0.
- Snapshot:
  - On every transition into ONES_ON, capture snap_tens<=seg_tens and snap_ones<=seg_ones.
  - Input changes mid-frame do not affect the current frame (no tearing).
- frame_tick: asserted for exactly the first cycle spent in ONES_ON.
- Outputs are registered and computed from next-state and next-snapshot values, so they change on the same edge as the state. Latency from state entry to pins is 0 cycles relative to the state register.
- ONES_ON: an_n=2'b10, seg_n=~snap_ones.
- TENS_ON:
  - Normally an_n=2'b01, seg_n=~snap_tens.
  - If lz_blank=1 and snap_tens==SEG_ZERO: an_n=2'b11, seg_n=7'h7F.
  - lz_blank is sampled live.
- BLANK_A, BLANK_B: an_n=2'b11, seg_n=7'h7F.
- en=0 overrides every state: an_n=2'b11, seg_n=7'h7F. State, cnt, snapshots and frame_tick continue unchanged.
- Invariant: at most one anode is low in any cycle. In particular, an_n is never 2'b00.
- Counter width is $clog2(max(REFRESH_DIV,BLANK_CYCLES,2)); terminal-count compares are exact, with no wrap past dwell-1.

Decomposition:
- Package ssd_pkg:
  - state enum {ONES_ON, BLANK_A, TENS_ON, BLANK_B}.
  - SEG_ZERO=7'b0111111.
  - SEG_OFF_N=7'h7F.
  - AN_OFF_N=2'b11.
- No sub-module. The dwell counter and FSM sit in one always block; output registers sit in a second.

Test Plan:
All cases use REFRESH_DIV=4, BLANK_CYCLES=2.

- Reset, then release with seg_tens=7'b1011011 ("2") and seg_ones=7'b1001111 ("3") → expected sequence:
  - 2 cycles an_n=11.
  - frame_tick=1 for one cycle, together with an_n=10, seg_n=7'b0110000 for 4 cycles.
  - 2 cycles an_n=11.
  - an_n=01, seg_n=7'b0100100 for 4 cycles.
  - Sequence repeats with a 12-cycle period.
- Change seg_ones to "7" (7'b0000111) during TENS_ON → the current frame is unchanged; the next ONES_ON shows seg_n=7'b1111000.
- seg_tens=SEG_ZERO with lz_blank=1 → TENS_ON slot shows an_n=11, seg_n=7F. With lz_blank=0 → an_n=01, seg_n=7'b1000000.
- Drop en for 5 cycles mid-ONES_ON → an_n=11, seg_n=7F during those cycles; slot boundaries and frame_tick timing are unchanged versus an en=1 run.
- Assert rst for 1 cycle mid-TENS_ON → next cycle an_n=11, seg_n=7F, frame_tick=0; first ONES_ON follows 2 cycles after release.
- Run with BLANK_CYCLES=0 for 3 frames → alternation is 10,10,10,10,01,01,01,01 with no 11 cycles. Across all runs an_n==00 is never observed (assertion).
